regfile: RTL
============

REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning register count (power of two, >=2); AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports.
REQ-004 SHALL have parameter NWR, default 2, meaning number of write ports.
REQ-005 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port rd_addr  input  NRD*AW  read addresses, port i at [i*AW +: AW].
REQ-008 SHALL have port rd_data  output  NRD*XLEN  read data, combinational, port i at [i*XLEN +: XLEN].
REQ-009 SHALL have port rd_busy  output  NRD  per read port: addressed register has a pending write.
REQ-010 SHALL have port wr_en  input  NWR  per-port write enable.
REQ-011 SHALL have port wr_addr  input  NWR*AW  write addresses.
REQ-012 SHALL have port wr_data  input  NWR*XLEN  write data.
REQ-013 SHALL have port rsv_en  input  1  request to reserve a destination register (issue).
REQ-014 SHALL have port rsv_addr  input  AW  register to reserve.
REQ-015 SHALL have port rsv_ok  output  1  combinational: reservation accepted this cycle.
REQ-016 SHALL have port flush  input  1  synchronous clear of all busy bits.
REQ-017 SHALL have port busy_cnt  output  AW+1  registered count of busy registers.

Function
REQ-018 SHALL store NREG x XLEN registers, written on rising clk edge when wr_en[j] and wr_addr[j] != 0.
REQ-019 SHALL hardwire register 0: reads return 0, writes ignored, never busy, reservation of 0 accepted with no effect.
REQ-020 SHALL resolve same-cycle writes to one address by highest port index winning.
REQ-021 SHALL keep one busy bit per register: set at the edge after an accepted reservation, cleared at the edge of any write to it.
REQ-022 SHALL assert rsv_ok = rsv_en && !flush && (rsv_addr==0 || !busy[rsv_addr] || rsv_addr is written this cycle); a rejected reservation changes no state (WAW stall).
REQ-023 SHALL, on same-cycle write and accepted reservation of one register, leave busy set (new reservation wins).
REQ-024 SHALL, on flush, clear all busy bits at the next edge; flush overrides same-cycle reservation; register writes still occur.
REQ-025 SHALL update busy_cnt every edge to the popcount of the next busy vector; range 0..NREG-1.
REQ-026 SHALL drive rd_busy[i] = busy[rd_addr[i]] masked per REQ-031/REQ-032.
REQ-027 SHALL add zero read latency (combinational read) and one-cycle write latency into storage.

Reset
REQ-028 SHALL, while rst_n low, clear all registers to 0, all busy bits to 0, busy_cnt to 0, independent of clk.
REQ-029 SHALL, with reset asserted mid-operation, discard pending writes and reservations of that cycle; rsv_ok and rd_busy SHALL read 0 during reset.
REQ-030 SHALL resume normal operation at the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL, with REGFILE_BYPASS_EN defined, forward same-cycle wr_data (highest matching port) to rd_data and force rd_busy[i]=0 when rd_addr[i] is being written.
REQ-032 SHALL, without REGFILE_BYPASS_EN, return stored contents only and report rd_busy from the stored busy bit; new value visible one cycle after the write.

Structure
REQ-033 SHALL place in shared package regfile_pkg: default XLEN/NREG/NRD/NWR constants, and a function computing AW.
REQ-034 SHALL implement the busy vector, reservation check and busy_cnt in sub-module regfile_sb; storage and read muxing stay in regfile.

Verification
REQ-035 SHALL test reset: write r5=0xDEADBEEF, pulse rst_n low between edges -> r5 reads 0, busy_cnt=0 immediately.
REQ-036 SHALL test bypass: wr_en[0], wr_addr=7, wr_data=0x12345678, rd_addr[0]=7 same cycle -> rd_data 0x12345678 with REGFILE_BYPASS_EN, previous value (0) without.
REQ-037 SHALL test write conflict: ports 0 and 1 both write r3 with 0xA and 0xB -> r3 reads 0xB next cycle.
REQ-038 SHALL test scoreboard: reserve r9 -> rsv_ok=1, busy_cnt=1, rd_busy=1 on r9; second reserve r9 -> rsv_ok=0; write r9 -> busy_cnt=0.
REQ-039 SHALL test flush: reserve r1,r2,r4 (busy_cnt=3), then flush with rsv_en on r6 -> busy_cnt=0 next cycle, rsv_ok=0.
REQ-040 SHALL test r0: write 0xFFFFFFFF to r0 and reserve r0 -> reads 0, rsv_ok=1, busy_cnt unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and its busy scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;
  localparam int NWR_DEF  = 2;

  // Address width for a register count; at least one bit so a 1-entry file still has a port.
  function automatic int calc_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/regfile_sb.sv
// Busy-bit scoreboard: tracks registers reserved by issue and awaiting a write,
// decides whether a new reservation may be accepted, and keeps a registered
// count of busy registers. Register 0 is never busy.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  parameter  int NWR  = NWR_DEF,
  localparam int AW   = calc_aw(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              flush,
  output logic [NREG-1:0]   busy,
  output logic              rsv_ok,
  output logic [AW:0]       busy_cnt
);

  localparam logic [NREG-1:0] R0_MASK = {{(NREG-1){1'b1}}, 1'b0};

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_nxt_s;
  logic [NREG-1:0] wr_hit_s;
  logic [NREG-1:0] rsv_set_s;
  logic            rsv_ok_s;
  logic [AW:0]     cnt_nxt_s;
  logic [AW:0]     busy_cnt_r;

  // Which registers receive a write this cycle (register 0 writes are dropped).
  always_comb begin
    wr_hit_s = '0;
    for (int j = 0; j < NWR; j++) begin
      for (int r = 0; r < NREG; r++) begin
        wr_hit_s[r] = wr_hit_s[r] | (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r)));
      end
    end
    wr_hit_s = wr_hit_s & R0_MASK;
  end

  // Reservation is accepted unless the target is still waiting on an earlier write.
  always_comb begin
    rsv_ok_s  = rst_n && rsv_en && !flush &&
                ((rsv_addr == {AW{1'b0}}) || !busy_r[rsv_addr] || wr_hit_s[rsv_addr]);
    rsv_set_s = {{(NREG-1){1'b0}}, rsv_ok_s} << rsv_addr;
  end

  // Next busy vector: writes clear, a new reservation sets (and wins), flush clears all.
  always_comb begin
    if (flush) begin
      busy_nxt_s = '0;
    end else begin
      busy_nxt_s = ((busy_r & ~wr_hit_s) | rsv_set_s) & R0_MASK;
    end
  end

  // Population count of the next busy vector.
  always_comb begin
    cnt_nxt_s = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt_s = cnt_nxt_s + {{AW{1'b0}}, busy_nxt_s[r]};
    end
  end

  // Busy bits and busy count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= '0;
      busy_cnt_r <= '0;
    end else begin
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= cnt_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign busy_cnt = busy_cnt_r;
  assign rsv_ok   = rsv_ok_s;

endmodule

// File: rtl/regfile.sv
// Multi-ported register file with a write-after-write busy scoreboard.
// Reads are combinational; writes land in storage at the next rising edge,
// with the highest-indexed write port winning on an address clash.
// Register 0 reads as zero and is never written or marked busy.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports and hide the busy bit of a register being written.
module regfile
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = NRD_DEF,
  parameter  int NWR  = NWR_DEF,
  localparam int AW   = calc_aw(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_ok,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]     mem_r     [NREG];
  logic [XLEN-1:0]     mem_nxt_s [NREG];
  logic [NREG-1:0]     busy_s;
  logic [NRD*XLEN-1:0] rd_data_s;
  logic [NRD-1:0]      rd_busy_s;

  regfile_sb #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .busy     (busy_s),
    .rsv_ok   (rsv_ok),
    .busy_cnt (busy_cnt)
  );

  // Storage next state: later ports are applied last so the highest index wins.
  always_comb begin
    mem_nxt_s = mem_r;
    for (int j = 0; j < NWR; j++) begin
      for (int r = 1; r < NREG; r++) begin
        mem_nxt_s[r] = (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) ?
                       wr_data[j*XLEN +: XLEN] : mem_nxt_s[r];
      end
    end
    mem_nxt_s[0] = '0;
  end

  // Storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        mem_r[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        mem_r[r] <= mem_nxt_s[r];
      end
    end
  end

  // Read ports: stored value and busy bit, optionally overridden by a same-cycle write.
  always_comb begin
    rd_data_s = '0;
    rd_busy_s = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data_s[i*XLEN +: XLEN] = mem_r[rd_addr[i*AW +: AW]];
      rd_busy_s[i]              = rst_n & busy_s[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        rd_data_s[i*XLEN +: XLEN] =
          (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW]) &&
           (rd_addr[i*AW +: AW] != {AW{1'b0}})) ?
          wr_data[j*XLEN +: XLEN] : rd_data_s[i*XLEN +: XLEN];
        rd_busy_s[i] = rd_busy_s[i] &
          ~(wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW]));
      end
`else
      rd_busy_s[i] = rd_busy_s[i];
`endif
    end
  end

  assign rd_data = rd_data_s;
  assign rd_busy = rd_busy_s;

endmodule
